// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : Instruction-fetch stage. Requests instructions over a req/ack
//            handshake and hands them to decode over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] sext_ext,
    input  logic [31:0] rf_rd1,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        id_ready,
    output logic [31:0] pc,
    output logic [31:0] npc_pc4,
    output logic        halt
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        req_q;
    logic        valid_q;
    logic        halt_q;
    logic [31:0] npc_d;
    logic [31:0] pc4;

    assign pc4 = pc_q + 32'd4;

    always_comb begin
        npc_d = pc4;
        case (npc_op)
            2'b00:   npc_d = pc4;
            2'b01:   npc_d = br_taken ? (pc_q + sext_ext) : pc4;
            2'b10:   npc_d = pc_q + sext_ext;
            default: npc_d = (rf_rd1 + sext_ext) & 32'hFFFF_FFFE;
        endcase
    end

    // Handshake flags are registered alongside the state so they never glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            case (state_q)
                S_BOOT: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        inst_q  <= imem_rdata;
                        state_q <= S_VALID;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (id_ready) begin
                        valid_q <= 1'b0;
                        if (npc_d[1:0] != 2'b00) begin
                            state_q <= S_HALT;
                            halt_q  <= 1'b1;
                        end else begin
                            pc_q    <= npc_d;
                            inst_q  <= NOP_INST;
                            state_q <= S_FETCH;
                            req_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign pc         = pc_q;
    assign npc_pc4    = pc4;
    assign halt       = halt_q;

endmodule
`default_nettype wire
